// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and iteration-counter sizing shared by
// alu_multicycle and alu_div_nr.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [2:0] {IDLE, EXEC, MUL_IT, DIV_IT, DIV_FIX, DONE} state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/alu_div_nr.sv
// alu_div_nr: unsigned non-restoring divider, one quotient bit per step plus a
// final remainder fix. Built only when ALU_DIV_EN is defined.
`ifdef ALU_DIV_EN
module alu_div_nr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic [WIDTH:0]   r, r_s, r_n;
   logic [WIDTH-1:0] q, d;

   // Dropping r[W] in the shift is safe: the true next remainder lies in [-d, d),
   // so modulo-2^(W+1) arithmetic still yields it exactly.
   assign r_s = {r[WIDTH-1:0], q[WIDTH-1]};
   assign r_n = r[WIDTH] ? r_s + {1'b0, d} : r_s - {1'b0, d};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r <= '0;
         q <= '0;
         d <= '0;
      end else if (load) begin
         r <= '0;
         q <= dividend;
         d <= divisor;
      end else if (step) begin
         r <= r_n;
         q <= {q[WIDTH-2:0], ~r_n[WIDTH]};
      end else if (fix && r[WIDTH]) begin
         r <= r + {1'b0, d};
      end
   end

   assign quotient  = q;
   assign remainder = r[WIDTH-1:0];
endmodule
`endif

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU (ADD/SUB, signed Booth MUL, unsigned DIV) with
// busy/done handshake and flags. Define ALU_DIV_EN to build the divider.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] inbus_a,
   input  logic [WIDTH-1:0] inbus_b,
   output logic [WIDTH-1:0] outbus,
   output logic [WIDTH-1:0] outbus_hi,
   output logic             busy,
   output logic             done,
   output logic             flag_zero,
   output logic             flag_carry,
   output logic             flag_ovf,
   output logic             flag_dbz
);
   localparam int CW = cnt_width(WIDTH);

   state_t             state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q, b_eff;
   logic [CW-1:0]      cnt;
   logic               ph;
   logic [WIDTH:0]     sum_q, sum_c, hi_ext, booth_hi;
   logic [2*WIDTH:0]   acc;
   logic [2*WIDTH-1:0] prod;
   logic               add_ovf, mul_ovf;

   assign b_eff    = (op_q == OP_ADD) ? b_q : ~b_q;
   assign sum_c    = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_q == OP_SUB};
   assign add_ovf  = (a_q[WIDTH-1] ~^ b_eff[WIDTH-1]) & (a_q[WIDTH-1] ^ sum_q[WIDTH-1]);
   // Booth partial sum kept one bit wider so -2^(W-1) multiplicands cannot overflow.
   assign hi_ext   = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
   assign booth_hi = (acc[1:0] == 2'b01) ? hi_ext + {a_q[WIDTH-1], a_q} :
                     (acc[1:0] == 2'b10) ? hi_ext - {a_q[WIDTH-1], a_q} : hi_ext;
   assign prod     = acc[2*WIDTH:1];
   assign mul_ovf  = !(&prod[2*WIDTH-1:WIDTH-1] || ~|prod[2*WIDTH-1:WIDTH-1]);

`ifdef ALU_DIV_EN
   logic [WIDTH-1:0] quo, rem;

   alu_div_nr #(.WIDTH(WIDTH)) u_div (
      .clk      (clk),
      .reset    (reset),
      .load     (state == DIV_IT && ph),
      .step     (state == DIV_IT && !ph),
      .fix      (state == DIV_FIX && ph),
      .dividend (a_q),
      .divisor  (b_q),
      .quotient (quo),
      .remainder(rem)
   );
`endif

   // ph marks the first cycle of a state: operand load/execute before iterating or committing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         cnt        <= '0;
         ph         <= 1'b0;
         sum_q      <= '0;
         acc        <= '0;
         outbus     <= '0;
         outbus_hi  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         flag_zero  <= 1'b0;
         flag_carry <= 1'b0;
         flag_ovf   <= 1'b0;
         flag_dbz   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_q  <= opcode;
               a_q   <= inbus_a;
               b_q   <= inbus_b;
               cnt   <= '0;
               ph    <= 1'b1;
               busy  <= 1'b1;
               state <= (opcode == OP_MUL) ? MUL_IT :
`ifdef ALU_DIV_EN
                        (opcode == OP_DIV && inbus_b != '0) ? DIV_IT :
`endif
                        EXEC;
            end
            EXEC: if (ph) begin
               sum_q <= sum_c;
               ph    <= 1'b0;
            end else begin
               if (op_q == OP_DIV) begin
`ifdef ALU_DIV_EN
                  outbus    <= '1;
                  outbus_hi <= a_q;
`else
                  outbus    <= '0;
                  outbus_hi <= '0;
`endif
                  flag_zero  <= 1'b0;
                  flag_carry <= 1'b0;
                  flag_ovf   <= 1'b0;
                  flag_dbz   <= 1'b1;
               end else begin
                  outbus     <= sum_q[WIDTH-1:0];
                  outbus_hi  <= '0;
                  flag_zero  <= sum_q[WIDTH-1:0] == '0;
                  flag_carry <= sum_q[WIDTH];
                  flag_ovf   <= add_ovf;
                  flag_dbz   <= 1'b0;
               end
               done  <= 1'b1;
               state <= DONE;
            end
            MUL_IT: if (ph) begin
               acc <= {{WIDTH{1'b0}}, b_q, 1'b0};
               ph  <= 1'b0;
            end else if (cnt != CW'(WIDTH)) begin
               acc <= {booth_hi, acc[WIDTH:1]};
               cnt <= cnt + 1'b1;
            end else begin
               outbus     <= prod[WIDTH-1:0];
               outbus_hi  <= prod[2*WIDTH-1:WIDTH];
               flag_zero  <= prod == '0;
               flag_carry <= 1'b0;
               flag_ovf   <= mul_ovf;
               flag_dbz   <= 1'b0;
               done       <= 1'b1;
               state      <= DONE;
            end
`ifdef ALU_DIV_EN
            DIV_IT: if (ph) begin
               ph <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  ph    <= 1'b1;
                  state <= DIV_FIX;
               end
            end
            DIV_FIX: if (ph) begin
               ph <= 1'b0;
            end else begin
               outbus     <= quo;
               outbus_hi  <= rem;
               flag_zero  <= quo == '0;
               flag_carry <= 1'b0;
               flag_ovf   <= 1'b0;
               flag_dbz   <= 1'b0;
               done       <= 1'b1;
               state      <= DONE;
            end
`endif
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed vectors for alu_multicycle (WIDTH=8); DIV expectations
// follow whether ALU_DIV_EN is defined.
module tb_alu_multicycle;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [1:0] opcode = 2'b00;
   logic [7:0] inbus_a = '0, inbus_b = '0;
   logic [7:0] outbus, outbus_hi;
   logic       busy, done, flag_zero, flag_carry, flag_ovf, flag_dbz;
   int         n_chk = 0, n_fail = 0;
   int         lat, n_done;

   alu_multicycle #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .opcode    (opcode),
      .inbus_a   (inbus_a),
      .inbus_b   (inbus_b),
      .outbus    (outbus),
      .outbus_hi (outbus_hi),
      .busy      (busy),
      .done      (done),
      .flag_zero (flag_zero),
      .flag_carry(flag_carry),
      .flag_ovf  (flag_ovf),
      .flag_dbz  (flag_dbz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1; opcode = op; inbus_a = a; inbus_b = b;
      @(posedge clk);
      #1 start = 1'b0; inbus_a = 8'h55; inbus_b = 8'h55;
   endtask

   task automatic wait_done(output int l);
      l = 0;
      do begin
         @(posedge clk);
         #1 l++;
      end while (!done && l < 40);
   endtask

   function automatic logic [3:0] flags();
      return {flag_zero, flag_carry, flag_ovf, flag_dbz};
   endfunction

   initial begin
      #12;
      check("reset_outputs", {outbus, outbus_hi, busy, done, flags()}, 0);
      @(negedge clk) reset = 1'b1;

      issue(2'b00, 8'd200, 8'd100); wait_done(lat);
      check("add_latency", lat, 2);
      check("add_result", {outbus_hi, outbus}, 16'd44);
      check("add_flags", flags(), 4'b0100);
      check("add_busy_at_done", busy, 1);
      @(posedge clk); #1;
      check("add_after_done", {busy, done}, 0);
      check("add_hold", outbus, 44);

      issue(2'b00, 8'h80, 8'h80); wait_done(lat);
      check("add_zero_result", outbus, 0);
      check("add_zero_flags", flags(), 4'b1110);

      issue(2'b01, 8'd25, 8'd10); wait_done(lat);
      check("sub1_result", outbus, 15);
      check("sub1_flags", flags(), 4'b0100);

      issue(2'b01, 8'd10, 8'd25); wait_done(lat);
      check("sub2_result", outbus, 241);
      check("sub2_flags", flags(), 4'b0000);

      issue(2'b10, 8'hFB, 8'h06); wait_done(lat);
      check("mul1_latency", lat, 10);
      check("mul1_result", {outbus_hi, outbus}, 16'hFFE2);
      check("mul1_flags", flags(), 4'b0000);

      issue(2'b10, 8'h80, 8'h80); wait_done(lat);
      check("mul2_result", {outbus_hi, outbus}, 16'h4000);
      check("mul2_flags", flags(), 4'b0010);

      issue(2'b10, 8'h00, 8'h93); wait_done(lat);
      check("mul_zero", {outbus_hi, outbus, flags()}, {16'h0000, 4'b1000});

`ifdef ALU_DIV_EN
      issue(2'b11, 8'd30, 8'd5); wait_done(lat);
      check("div1_latency", lat, 11);
      check("div1_result", {outbus_hi, outbus, flags()}, {8'd0, 8'd6, 4'b0000});
      issue(2'b11, 8'd200, 8'd7); wait_done(lat);
      check("div2_result", {outbus_hi, outbus}, {8'd4, 8'd28});
      issue(2'b11, 8'd3, 8'd9); wait_done(lat);
      check("div3_result", {outbus_hi, outbus, flags()}, {8'd3, 8'd0, 4'b1000});
      issue(2'b11, 8'd30, 8'd0); wait_done(lat);
      check("dbz_latency", lat, 2);
      check("dbz_result", {outbus_hi, outbus, flags()}, {8'd30, 8'hFF, 4'b0001});
`else
      issue(2'b11, 8'd30, 8'd5); wait_done(lat);
      check("div_off_latency", lat, 2);
      check("div_off_result", {outbus_hi, outbus, flags()}, {16'h0000, 4'b0001});
`endif

      // A start pulsed mid-MUL must neither alter it nor queue a second op.
      issue(2'b10, 8'd3, 8'd4);
      @(negedge clk) start = 1'b1; opcode = 2'b00; inbus_a = 8'd1; inbus_b = 8'd1;
      @(negedge clk) start = 1'b0;
      wait_done(lat);
      check("ignore_latency", lat, 9);
      check("ignore_result", {outbus_hi, outbus}, 16'd12);
      n_done = 0;
      repeat (4) begin
         @(posedge clk); #1;
         n_done += int'(done);
      end
      check("ignore_no_queue", {n_done[7:0], 7'd0, busy}, 0);

      // Reset during MUL iteration 4 clears everything at once and suppresses done.
      issue(2'b10, 8'hFB, 8'h06);
      repeat (5) @(posedge clk);
      #2 reset = 1'b0;
      #1 check("async_reset", {outbus, outbus_hi, busy, done, flags()}, 0);
      @(negedge clk) reset = 1'b1;
      n_done = 0;
      repeat (15) begin
         @(posedge clk); #1;
         n_done += int'(done);
      end
      check("reset_no_done", n_done, 0);

      issue(2'b00, 8'd7, 8'd8); wait_done(lat);
      check("post_reset_add", {lat[7:0], outbus}, {8'd2, 8'd15});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
